// File: rtl/sort_stream_io.sv
// rtl/sort_stream_io.sv - stream load/kick/drain front end for the bubble-sort core
// Optional feature macro: SORT_IO_REVERSE_EN (drain reads the RAM from the top address down).
module sort_stream_io #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] core_data_in,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_wr,
  output logic              core_rd,
  output logic              core_start,
  input  logic              core_eoc,
  input  logic [DATA_W-1:0] core_data_out,
  output logic              busy,
  output logic [1:0]        phase
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     wr_cnt, rd_cnt, tx_cnt, rd_idx;
  logic              eoc_q, eoc_armed;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr, in_flight;
  logic [1:0]        fifo_cnt;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q, start_q;
  logic              s_fire, m_fire, rd_issue, eoc_edge, last_word, last_pop;

  assign s_ready   = (state == LOAD);
  assign s_fire    = s_valid & s_ready;
  assign m_valid   = (fifo_cnt != 2'd0);
  assign m_data    = fifo_mem[rd_ptr];
  assign m_fire    = m_valid & m_ready;
  // The armed flag makes a level that was already high when SORT began count
  // only after it has been seen low at least once.
  assign eoc_edge  = core_eoc & ~eoc_q & eoc_armed;
  assign last_word = s_fire && (wr_cnt == CW'(DEPTH - 1));
  assign last_pop  = m_fire && (tx_cnt == CW'(DEPTH - 1));

  // Slots in use are FIFO words plus the read whose data lands next cycle; a
  // pop this cycle frees its slot in time for a new read.
  assign pending  = 3'(fifo_cnt) + 3'(in_flight);
  assign rd_issue = (state == DRAIN) && (rd_cnt < CW'(DEPTH)) &&
                    ((pending - 3'(m_fire)) < 3'd2);

`ifdef SORT_IO_REVERSE_EN
  assign rd_idx = CW'(DEPTH - 1) - rd_cnt;
`else
  assign rd_idx = rd_cnt;
`endif

  // Reads drive the address combinationally so data arrives in time for the
  // two-cycle first-word latency; otherwise the last strobed address is held.
  assign core_addr    = rd_issue ? ADDR_W'(rd_idx) : addr_q;
  assign core_rd      = rd_issue;
  assign core_wr      = wr_q;
  assign core_data_in = wdata_q;
  assign core_start   = start_q;
  assign busy         = (state != LOAD);
  assign phase        = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (last_word) state_nx = KICK;
      KICK:    state_nx = SORT;
      SORT:    if (eoc_edge) state_nx = DRAIN;
      DRAIN:   if (last_pop) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Load path: register the RAM write one cycle after each accepted word, and
  // raise start the cycle after the final write has gone out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      wr_q    <= s_fire;
      start_q <= (state == KICK);
      if (state == KICK)  wr_cnt <= '0;
      else if (s_fire)    wr_cnt <= wr_cnt + 1'b1;
      if (s_fire) begin
        addr_q  <= ADDR_W'(wr_cnt);
        wdata_q <= s_data;
      end else if (rd_issue) begin
        addr_q  <= ADDR_W'(rd_idx);
      end
    end
  end

  // End-of-conversion edge detector, cleared as the sort is kicked off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eoc_q     <= 1'b0;
      eoc_armed <= 1'b0;
    end else if (state == KICK) begin
      eoc_q     <= 1'b0;
      eoc_armed <= 1'b0;
    end else begin
      eoc_q <= core_eoc;
      if (state == SORT && !core_eoc) eoc_armed <= 1'b1;
    end
  end

  // Drain bookkeeping: read counter, in-flight flag, FIFO pointers and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt    <= '0;
      tx_cnt    <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else if (state == SORT && eoc_edge) begin
      rd_cnt    <= '0;
      tx_cnt    <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      in_flight <= rd_issue;
      if (rd_issue)  rd_cnt <= rd_cnt + 1'b1;
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (m_fire) begin
        rd_ptr <= ~rd_ptr;
        tx_cnt <= tx_cnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + 2'(in_flight) - 2'(m_fire);
    end
  end

  // FIFO storage: read data is captured the cycle after its strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else if (in_flight && state == DRAIN) begin
      fifo_mem[wr_ptr] <= core_data_out;
    end
  end

endmodule
